// File: rtl/sha256_compress_engine.sv
// Iterative SHA-224/256 compression engine: one padded 512-bit block per start,
// ROUNDS_PER_CYCLE rounds per clock, internal message schedule, chaining state and digest.
module sha256_compress_engine #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         first_block,
  input  logic         mode,
  input  logic         abort,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_ROUND = 6'(64 - R);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUNDS = 2'd1;
  localparam logic [1:0] FINAL  = 2'd2;

  localparam logic [255:0] IV_256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV_224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                     32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
    $error("sha256_compress_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // 3:2 compressor, returns {carry, sum}; the carry is pre-shifted and truncated mod 2^32
  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [31:0] maj_bits;
    maj_bits = (x & y) | (x & z) | (y & z);
    return {maj_bits[30:0], 1'b0, x ^ y ^ z};
  endfunction

  // One round on the packed working set {a,b,c,d,e,f,g,h}
  function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] hkw, dhkw, sig0, sig1, ch, mj, a_new, e_new;
    logic [63:0] t_cs, a1_cs, a2_cs, e_cs;
    {a, b, c, d, e, f, g, h} = v;
    hkw   = h + k + w;
    dhkw  = d + hkw;
    sig1  = big_sigma1(e);
    ch    = (e & f) ^ (~e & g);
    sig0  = big_sigma0(a);
    mj    = (a & b) ^ (a & c) ^ (b & c);
    t_cs  = csa(hkw, sig1, ch);
    a1_cs = csa(t_cs[31:0], t_cs[63:32], sig0);
    a2_cs = csa(a1_cs[31:0], a1_cs[63:32], mj);
    e_cs  = csa(dhkw, sig1, ch);
    a_new = a2_cs[31:0] + a2_cs[63:32];
    e_new = e_cs[31:0] + e_cs[63:32];
    return {a_new, a, b, c, e_new, e, f, g};
  endfunction

  logic [1:0]   state;
  logic [5:0]   round;
  logic         mode_q;
  logic [255:0] h_reg;
  logic [255:0] wv;
  logic [31:0]  win [16];

  logic         mode_eff;
  logic [255:0] iv_sel;
  logic [31:0]  ext [16+R];
  logic [255:0] stage [R+1];
  logic [255:0] h_sum;
  logic [255:0] digest_nxt;

  assign mode_eff = SUPPORT_224 ? mode : 1'b0;
  assign iv_sel   = mode_eff ? IV_224 : IV_256;
  assign ready    = (state == IDLE);

  // ext[0..15] is the current window (ext[0] = W[round]); ext[16..] are the words shifted in this clock
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < R; j++)
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    stage[0] = wv;
    for (int j = 0; j < R; j++)
      stage[j+1] = sha_round(stage[j], K_ROM[round + 6'(j)], ext[j]);
  end

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[32*i +: 32] = h_reg[32*i +: 32] + wv[32*i +: 32];
    digest_nxt = {h_sum[255:32], mode_q ? 32'h0 : h_sum[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      round        <= '0;
      mode_q       <= 1'b0;
      h_reg        <= '0;
      wv           <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
            round <= '0;
            if (first_block) begin
              wv     <= iv_sel;
              h_reg  <= iv_sel;
              mode_q <= mode_eff;
            end else begin
              wv <= h_reg;
            end
            state <= ROUNDS;
          end
        end
        ROUNDS: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            for (int i = 0; i < 16; i++) win[i] <= ext[i+R];
            wv    <= stage[R];
            round <= round + 6'(R);
            if (round == LAST_ROUND) state <= FINAL;
          end
        end
        FINAL: begin
          state <= IDLE;
          if (!abort) begin
            h_reg        <= h_sum;
            digest       <= digest_nxt;
            digest_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_engine.sv
// Bench for sha256_compress_engine: three instances (1, 2, 4 rounds/clock) share stimulus and are
// checked against a plain-arithmetic SHA-256/224 reference model plus known digests.
module tb_sha256_compress_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, first_block, mode, abort;
  logic [511:0] block_in;
  logic         rdy [3];
  logic         dv [3];
  logic [255:0] dg [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_q [$];
  logic [255:0] seen_dig [3];

  localparam int RV  [3] = '{1, 2, 4};
  localparam int LAT [3] = '{66, 34, 18};

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC_256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC_224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] TWO_256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_compress_engine #(.ROUNDS_PER_CYCLE(1), .SUPPORT_224(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .start(start), .first_block(first_block), .mode(mode), .abort(abort),
    .block_in(block_in), .ready(rdy[0]), .digest_valid(dv[0]), .digest(dg[0]));
  sha256_compress_engine #(.ROUNDS_PER_CYCLE(2), .SUPPORT_224(1'b1)) u_r2 (
    .clk(clk), .rst(rst), .start(start), .first_block(first_block), .mode(mode), .abort(abort),
    .block_in(block_in), .ready(rdy[1]), .digest_valid(dv[1]), .digest(dg[1]));
  sha256_compress_engine #(.ROUNDS_PER_CYCLE(4), .SUPPORT_224(1'b1)) u_r4 (
    .clk(clk), .rst(rst), .start(start), .first_block(first_block), .mode(mode), .abort(abort),
    .block_in(block_in), .ready(rdy[2]), .digest_valid(dv[2]), .digest(dg[2]));

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  logic [31:0] exp_h [8];
  logic        exp_mode;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_h[i] = 32'h0;
    exp_mode = 1'b0;
  endtask

  task automatic model_accept(input logic fb, input logic md, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    if (fb) begin
      for (int i = 0; i < 8; i++) exp_h[i] = md ? iv224[i] : iv256[i];
      exp_mode = md;
    end
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = exp_h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + k_tab[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) exp_h[i] = exp_h[i] + v[i];
  endtask

  function automatic logic [255:0] model_digest();
    return {exp_h[0], exp_h[1], exp_h[2], exp_h[3], exp_h[4], exp_h[5], exp_h[6],
            exp_mode ? 32'h0 : exp_h[7]};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ready_r%0d", tag, RV[d]), rdy[d], 1);
      check($sformatf("%s_dvalid_r%0d", tag, RV[d]), dv[d], 0);
      check($sformatf("%s_digest_r%0d", tag, RV[d]), dg[d], '0);
    end
  endtask

  // driver: one start, bounded observation window of 70 cycles
  task automatic run_block(input logic fb, input logic md, input logic [511:0] blk,
                           input bit spam, input int abort_at);
    int pulses [3];
    @(negedge clk);
    start = 1'b1; first_block = fb; mode = md; block_in = blk; abort = 1'b0;
    if (abort_at == 0) model_accept(fb, md, blk);
    exp_q.push_back(model_digest());
    for (int d = 0; d < 3; d++) begin
      pulses[d] = 0;
      seen_dig[d] = '0;
    end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (dv[d]) begin
          pulses[d]++;
          check($sformatf("latency_r%0d", RV[d]), k, LAT[d]);
          check($sformatf("digest_r%0d", RV[d]), dg[d], exp_q[0]);
          check($sformatf("ready_at_valid_r%0d", RV[d]), rdy[d], 1);
          seen_dig[d] = dg[d];
        end
      end
      start = spam && (k <= 16);
      if (spam) begin
        block_in    = rand_block();
        first_block = 1'($urandom_range(0, 1));
        mode        = 1'($urandom_range(0, 1));
      end
      abort = (k == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("pulse_count_r%0d", RV[d]), pulses[d], (abort_at == 0) ? 1 : 0);
      check($sformatf("idle_after_r%0d", RV[d]), rdy[d], 1);
      if (abort_at != 0) check($sformatf("digest_hold_r%0d", RV[d]), dg[d], exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic check_known(input string tag, input logic [255:0] exp);
    for (int d = 0; d < 3; d++) check($sformatf("%s_r%0d", tag, RV[d]), seen_dig[d], exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; first_block = 1'b0; mode = 1'b0; abort = 1'b0; block_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_block(1'b1, 1'b0, ABC_BLK, 1'b0, 0);
    check_known("abc_sha256", ABC_256);

    run_block(1'b1, 1'b1, ABC_BLK, 1'b0, 0);
    check_known("abc_sha224", ABC_224);

    run_block(1'b1, 1'b0, TWO_B1, 1'b0, 0);
    run_block(1'b0, 1'b1, TWO_B2, 1'b0, 0);
    check_known("two_block", TWO_256);

    run_block(1'b1, 1'b0, ABC_BLK, 1'b1, 0);
    check_known("start_spam", ABC_256);

    run_block(1'b1, 1'b0, TWO_B1, 1'b0, 0);
    run_block(1'b0, 1'b0, TWO_B2, 1'b0, 16);
    run_block(1'b0, 1'b0, TWO_B2, 1'b0, 0);
    check_known("abort_resend", TWO_256);

    // abort together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; abort = 1'b1; first_block = 1'b1; mode = 1'b1; block_in = ABC_BLK;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int d = 0; d < 3; d++) check($sformatf("abort_start_idle_r%0d", RV[d]), rdy[d], 1);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("abort_start_digest_r%0d", RV[d]), dg[d], TWO_256);

    // reset at round 10 of the single-round instance
    @(negedge clk);
    start = 1'b1; first_block = 1'b1; mode = 1'b0; block_in = ABC_BLK;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midblock_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_block(1'b1, 1'b0, ABC_BLK, 1'b0, 0);
    check_known("after_rst", ABC_256);

    for (int i = 0; i < 6; i++) begin
      run_block((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_block(),
                1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
